// File: rtl/pwm_duty_sequencer_if.sv
// Command channel into the PWM duty sequencer: valid/ready handshake with target duty.
// master = command source (register block / supervisor), slave = sequencer.
// Ports: cmd_valid (command presented), cmd_duty (target duty in ticks), cmd_ready (accept allowed).
`timescale 1ns/1ps
interface pwm_duty_sequencer_if #(
    parameter int DUTY_W = 5
);
    logic              cmd_valid;
    logic [DUTY_W-1:0] cmd_duty;
    logic              cmd_ready;

    modport master (output cmd_valid, output cmd_duty, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_duty, output cmd_ready);
endinterface

// File: rtl/pwm_duty_sequencer.sv
// PWM duty sequencer: prescaler + period counter, duty command intake, period-aligned duty slewing.
// Latency: duty_cur changes on the edge that raises period_start; pwm_out follows one cycle later.
// Backpressure: cmd_ready is low while ramping, under kill and in reset; commands offered then are dropped.
//
// Ports: clk_1MHz, rst_n (sync, active low); cmd (slave side of pwm_duty_sequencer_if);
//        kill (level, forces shutdown); pwm_out, duty_cur, period_start (1-cycle strobe), busy (ramping).
// Build option: PWM_SEQ_RAMP_EN defined -> stepped ramp (STEP per DWELL periods);
//               undefined -> duty loads the target directly at the next period boundary.
`timescale 1ns/1ps
module pwm_duty_sequencer #(
    parameter int PRESCALE = 50,
    parameter int PERIOD   = 20,
    parameter int DUTY_W   = 5
`ifdef PWM_SEQ_RAMP_EN
    ,
    parameter int STEP     = 1,
    parameter int DWELL    = 4
`endif
) (
    input  logic                    clk_1MHz,
    input  logic                    rst_n,
    pwm_duty_sequencer_if.slave     cmd,
    input  logic                    kill,
    output logic                    pwm_out,
    output logic [DUTY_W-1:0]       duty_cur,
    output logic                    period_start,
    output logic                    busy
);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int PH_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int CMP_W = (PH_W > DUTY_W) ? PH_W : DUTY_W;

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RAMP = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t            state_q;
    logic [PRE_W-1:0]  pre_cnt_q;
    logic [PH_W-1:0]   phase_q;
    logic [DUTY_W-1:0] duty_cur_q;
    logic [DUTY_W-1:0] target_q;
    logic              period_start_q;
    logic              pwm_out_q;
    logic              busy_q;

    logic              tick;
    logic              wrap;
    logic              cmd_ready;
    logic              accept;
    logic [DUTY_W-1:0] cmd_clamped;

    assign tick        = (pre_cnt_q == PRE_LAST);
    // wrap marks the edge on which phase returns to 0; period_start is its registered echo,
    // so duty changes made on this edge line up exactly with the new period.
    assign wrap        = tick && (phase_q == PH_LAST);
    assign cmd_ready   = rst_n && !kill && (state_q != S_RAMP);
    assign accept      = cmd.cmd_valid && cmd_ready;
    assign cmd_clamped = (cmd.cmd_duty > DUTY_MAX) ? DUTY_MAX : cmd.cmd_duty;

    assign cmd.cmd_ready = cmd_ready;
    assign pwm_out       = pwm_out_q;
    assign duty_cur      = duty_cur_q;
    assign period_start  = period_start_q;
    assign busy          = busy_q;

`ifdef PWM_SEQ_RAMP_EN
    localparam int                DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]   DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [DUTY_W-1:0] STEP_D     = DUTY_W'(STEP);

    logic [DW_W-1:0]   dwell_q;
    logic [DUTY_W-1:0] duty_step_d;

    // One STEP toward target, landing exactly on target when closer than STEP.
    // Differences are taken larger-minus-smaller so nothing wraps below zero.
    always_comb begin
        duty_step_d = target_q;
        if (duty_cur_q < target_q) begin
            if ((target_q - duty_cur_q) > STEP_D) duty_step_d = duty_cur_q + STEP_D;
        end else if ((duty_cur_q - target_q) > STEP_D) begin
            duty_step_d = duty_cur_q - STEP_D;
        end
    end
`endif

    always_ff @(posedge clk_1MHz) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            pre_cnt_q      <= '0;
            phase_q        <= '0;
            duty_cur_q     <= '0;
            target_q       <= '0;
            period_start_q <= 1'b0;
            pwm_out_q      <= 1'b0;
            busy_q         <= 1'b0;
`ifdef PWM_SEQ_RAMP_EN
            dwell_q        <= '0;
`endif
        end else begin
            // Timebase runs regardless of kill so the period grid never shifts.
            pre_cnt_q      <= tick ? '0 : pre_cnt_q + PRE_W'(1);
            if (tick) phase_q <= (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
            period_start_q <= wrap;
            pwm_out_q      <= (CMP_W'(phase_q) < CMP_W'(duty_cur_q)) && !kill;

            if (kill) begin
                state_q    <= S_IDLE;
                duty_cur_q <= '0;
                target_q   <= '0;
                busy_q     <= 1'b0;
`ifdef PWM_SEQ_RAMP_EN
                dwell_q    <= '0;
`endif
            end else if (accept) begin
                target_q <= cmd_clamped;
`ifdef PWM_SEQ_RAMP_EN
                dwell_q  <= '0;
`endif
                if (cmd_clamped == duty_cur_q) begin
                    state_q <= S_HOLD;
                    busy_q  <= 1'b0;
                end else begin
                    state_q <= S_RAMP;
                    busy_q  <= 1'b1;
                end
            end else if ((state_q == S_RAMP) && wrap) begin
`ifdef PWM_SEQ_RAMP_EN
                if (dwell_q == DWELL_LAST) begin
                    duty_cur_q <= duty_step_d;
                    dwell_q    <= '0;
                    if (duty_step_d == target_q) begin
                        state_q <= S_HOLD;
                        busy_q  <= 1'b0;
                    end
                end else begin
                    dwell_q <= dwell_q + DW_W'(1);
                end
`else
                duty_cur_q <= target_q;
                state_q    <= S_HOLD;
                busy_q     <= 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Bench for pwm_duty_sequencer: directed scenarios plus random commands/kill pulses,
// every cycle compared against a time-based behavioural model of the sequencer.
`timescale 1ns/1ps
module tb_pwm_duty_sequencer;
    localparam int PRESCALE = 50;
    localparam int PERIOD   = 20;
    localparam int DUTY_W   = 5;
    localparam int FRAME    = PRESCALE * PERIOD;
`ifdef PWM_SEQ_RAMP_EN
    localparam int STEP     = 1;
    localparam int DWELL    = 4;
    localparam int SETTLE   = (PERIOD / STEP + 2) * DWELL * FRAME;
`else
    localparam int SETTLE   = 3 * FRAME;
`endif

    logic              clk_1MHz = 1'b0;
    logic              rst_n    = 1'b0;
    logic              kill     = 1'b0;
    logic              pwm_out;
    logic [DUTY_W-1:0] duty_cur;
    logic              period_start;
    logic              busy;

    pwm_duty_sequencer_if #(.DUTY_W(DUTY_W)) cmd_if ();

    pwm_duty_sequencer #(
        .PRESCALE (PRESCALE),
        .PERIOD   (PERIOD),
        .DUTY_W   (DUTY_W)
    ) dut (
        .clk_1MHz     (clk_1MHz),
        .rst_n        (rst_n),
        .cmd          (cmd_if),
        .kill         (kill),
        .pwm_out      (pwm_out),
        .duty_cur     (duty_cur),
        .period_start (period_start),
        .busy         (busy)
    );

    always #500 clk_1MHz = ~clk_1MHz;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: time since reset release gives the timebase directly;
    // duty/target/mode follow the command, ramp and kill rules.
    typedef enum int {M_IDLE, M_RAMP, M_HOLD} mode_t;
    mode_t m_mode   = M_IDLE;
    int    m_n      = 0;
    int    m_duty   = 0;
    int    m_target = 0;
    int    m_cnt    = 0;
    bit    m_pwm    = 1'b0;
    bit    m_ps     = 1'b0;

    function automatic int phase_at(input int n);
        return (n / PRESCALE) % PERIOD;
    endfunction

    task automatic cycle();
        bit exp_rdy;
        int req;
        #1;
        exp_rdy = rst_n && !kill && (m_mode != M_RAMP);
        check("cmd_ready", 32'(cmd_if.cmd_ready), 32'(exp_rdy));
        req = int'(cmd_if.cmd_duty);
        @(posedge clk_1MHz);
        if (!rst_n) begin
            m_n = 0; m_duty = 0; m_target = 0; m_cnt = 0;
            m_mode = M_IDLE; m_pwm = 1'b0; m_ps = 1'b0;
        end else begin
            m_pwm = (phase_at(m_n) < m_duty) && !kill;
            m_n++;
            m_ps = (m_n % FRAME) == 0;
            if (kill) begin
                m_mode = M_IDLE; m_duty = 0; m_target = 0; m_cnt = 0;
            end else if (cmd_if.cmd_valid && exp_rdy) begin
                m_target = (req > PERIOD) ? PERIOD : req;
                m_cnt    = 0;
                m_mode   = (m_target == m_duty) ? M_HOLD : M_RAMP;
            end else if (m_mode == M_RAMP && m_ps) begin
`ifdef PWM_SEQ_RAMP_EN
                m_cnt++;
                if (m_cnt == DWELL) begin
                    m_cnt  = 0;
                    m_duty = (m_duty < m_target) ? ((m_duty + STEP > m_target) ? m_target : m_duty + STEP)
                                                 : ((m_duty - STEP < m_target) ? m_target : m_duty - STEP);
                    if (m_duty == m_target) m_mode = M_HOLD;
                end
`else
                m_duty = m_target;
                m_mode = M_HOLD;
`endif
            end
        end
        #1;
        check("pwm_out", 32'(pwm_out), 32'(m_pwm));
        check("duty_cur", 32'(duty_cur), 32'(m_duty));
        check("period_start", 32'(period_start), 32'(m_ps));
        check("busy", 32'(busy), 32'(m_mode == M_RAMP));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input int d);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_duty  = DUTY_W'(d);
        cycle();
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic settle(input string tag);
        int k = 0;
        while (busy && k < SETTLE) begin
            cycle();
            k++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    // Aligns to a period boundary, then counts high cycles over one full period.
    task automatic count_high(output int hi);
        int k = 0;
        while (!period_start && k < 2 * FRAME) begin
            cycle();
            k++;
        end
        hi = 0;
        for (int i = 0; i < FRAME; i++) begin
            cycle();
            hi += int'(pwm_out);
        end
    endtask

    initial begin
        int k;
        int hi;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_duty  = '0;

        // Reset held for 5 cycles: all outputs zero, not ready.
        rst_n = 1'b0;
        run(5);
        check("rst_pwm", 32'(pwm_out), 32'd0);
        check("rst_duty", 32'(duty_cur), 32'd0);
        check("rst_ready", 32'(cmd_if.cmd_ready), 32'd0);

        // Release: ready at once, first period_start FRAME cycles later.
        rst_n = 1'b1;
        #1;
        check("rel_ready", 32'(cmd_if.cmd_ready), 32'd1);
        k = 0;
        while (!period_start && k < FRAME + 100) begin
            cycle();
            k++;
        end
        check("first_ps_cycles", 32'(k), 32'(FRAME));

        // Ramp to 4, then 200 high cycles per period.
        send(4);
        settle("ramp4_settle");
        check("ramp4_duty", 32'(duty_cur), 32'd4);
        count_high(hi);
        check("ramp4_high", 32'(hi), 32'(4 * PRESCALE));

        // Clamp: 25 becomes 20, output constantly high.
        send(25);
        settle("clamp_settle");
        check("clamp_duty", 32'(duty_cur), 32'(PERIOD));
        count_high(hi);
        check("clamp_high", 32'(hi), 32'(FRAME));

        // Back down to 0 without underflow.
        send(0);
        settle("down_settle");
        check("down_duty", 32'(duty_cur), 32'd0);

        // Command offered mid-ramp is dropped.
        send(8);
        check("ign_busy", 32'(busy), 32'd1);
        send(10);
        settle("ign_settle");
        check("ign_duty", 32'(duty_cur), 32'd8);

        // Kill mid-ramp.
        send(12);
        run(3);
        kill = 1'b1;
        #1;
        check("kill_ready", 32'(cmd_if.cmd_ready), 32'd0);
        cycle();
        check("kill_pwm", 32'(pwm_out), 32'd0);
        check("kill_duty", 32'(duty_cur), 32'd0);
        run(3);
        kill = 1'b0;
        #1;
        check("unkill_ready", 32'(cmd_if.cmd_ready), 32'd1);
        check("unkill_busy", 32'(busy), 32'd0);

        // Reset in the middle of a ramp.
        send(15);
        run(2);
        rst_n = 1'b0;
        cycle();
        check("rstmid_duty", 32'(duty_cur), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_ready", 32'(cmd_if.cmd_ready), 32'd0);
        rst_n = 1'b1;
        run(3);

        // Random commands, stray valids and kill pulses against the model.
        for (int it = 0; it < 14; it++) begin
            send(int'($urandom_range(0, 31)));
            run(int'($urandom_range(1, 400)));
            if ($urandom_range(0, 2) == 0) send(int'($urandom_range(0, 31)));
            if ($urandom_range(0, 4) == 0) begin
                kill = 1'b1;
                run(int'($urandom_range(1, 3)));
                kill = 1'b0;
            end
            run(int'($urandom_range(0, 1500)));
        end
        settle("rand_settle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_duty_sequencer.md
# pwm_duty_sequencer

Controller that sequences a PWM datapath: owns the clock prescaler and period counter, accepts duty-cycle commands over a valid/ready handshake, and slews the applied duty toward the target in fixed steps. Duty changes take effect only on PWM period boundaries, so every period on `pwm_out` is glitch-free. It sits between the command source (register block or supervisor FSM) and the PWM output pin, with a `kill` input for immediate shutdown.

## Interface
- `PRESCALE`, 50: `clk_1MHz` cycles per PWM tick.
- `PERIOD`, 20: ticks per PWM period, which is also the 100% duty value.
- `DUTY_W`, 5: duty width. Must satisfy 2^DUTY_W > PERIOD.
- `STEP`, 1: duty change per ramp step.
- `DWELL`, 4: PWM periods between ramp steps (≥1).

Ports:
- `clk_1MHz` input 1: the single clock; all logic is on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `cmd_valid` input 1: a command is presented.
- `cmd_duty` input DUTY_W: target duty in ticks.
- `cmd_ready` output 1: the block can accept a command.
- `kill` input 1: level-sensitive forced shutdown, highest priority.
- `pwm_out` output 1: PWM waveform.
- `duty_cur` output DUTY_W: duty currently applied.
- `period_start` output 1: one-cycle strobe when `phase` wraps to 0.
- `busy` output 1: high while in RAMP.

## Operation
- **Prescaler:** `pre_cnt` runs 0..PRESCALE-1. `tick` = (`pre_cnt` == PRESCALE-1).
- **Phase counter:** `phase` runs 0..PERIOD-1 and advances on `tick`. `period_start` is registered and pulses on the cycle after `tick` && `phase` == PERIOD-1.
- **Output compare:** each clock, `pwm_out` <= (`phase` < `duty_cur`) && !`kill`.
- **Handshake:**
  - `cmd_ready` = rst_n && !kill && (state != RAMP), decoded combinationally.
  - A command is accepted when `cmd_valid` && `cmd_ready`.
  - `cmd_duty` > PERIOD is clamped to PERIOD, and the clamped value is latched as `target`.
  - `cmd_valid` while `cmd_ready` is low is ignored, not queued.
- **States:**
  - IDLE (reset and kill state, `duty_cur` = 0): on accept, go to HOLD if `target` == `duty_cur`, else to RAMP.
  - RAMP: the `dwell` counter clears on accept and counts `period_start` pulses. On the `period_start` where `dwell` == DWELL-1:
    - `duty_cur` moves STEP toward `target`, saturating exactly at `target` (never overshoots).
    - `dwell` clears.
    - If the new `duty_cur` == `target`, go to HOLD.
  - HOLD: `duty_cur` is stable. Accept behaves as in IDLE.
- **Kill:** while `kill` is high:
  - state goes to IDLE, `duty_cur` goes to 0, `dwell` clears, `target` goes to 0.
  - The prescaler and phase counter keep running.
- **Arithmetic:** ramp-down compares `duty_cur` − `target` ≤ STEP before subtracting, so there is no unsigned underflow.

## Timing
- **Reset values:**
  - `pwm_out`, `duty_cur`, `period_start`, `busy` = 0.
  - `cmd_ready` = 0 while `rst_n` is low.
  - State IDLE; `phase`, `pre_cnt`, `dwell`, `target` = 0.
- **After reset release:** `cmd_ready` = 1 in the first cycle. The first `period_start` comes PRESCALE×PERIOD cycles after release.
- **Accept to state change:** the state is RAMP in the cycle after accept, so `cmd_ready` drops one cycle after the accepting edge.
- **Duty update:** `duty_cur` updates in the same cycle as the qualifying `period_start`. `pwm_out` reflects it one cycle later, at `phase` 0.
- **Kill latency:** `kill` rising forces `pwm_out` = 0 on the next edge. After `kill` falls, `cmd_ready` = 1 in the same cycle.
- **Reset mid-ramp:** the next edge returns every register to its reset value.
- **Simultaneous kill and accept:** cannot occur, because `cmd_ready` is low while `kill` is high.

## Configuration
- `PWM_SEQ_RAMP_EN` defined: ramp behaviour as described above.
- `PWM_SEQ_RAMP_EN` undefined:
  - `dwell` and STEP logic are removed.
  - RAMP lasts until the next `period_start`, where `duty_cur` loads `target` directly, and the state then goes to HOLD.
  - The handshake, clamp and kill behave as described above.

## Test plan
- **Reset:** hold `rst_n` low 5 cycles → all outputs 0. Release → first `period_start` 1000 cycles later, `cmd_ready` = 1.
- **Ramp up:** from IDLE, accept `cmd_duty` = 4 →
  - `duty_cur` = 1, 2, 3, 4 on the 4th, 8th, 12th and 16th `period_start` after accept.
  - `busy` falls with the 4th step.
  - In HOLD, `pwm_out` is high 200 of every 1000 cycles.
- **Clamp:** accept 25 → `target` = 20, and `pwm_out` is constantly high after the ramp completes. In HOLD, accept 0 → steps down to 0, no underflow.
- **Ignored command:** pulse `cmd_valid` with `cmd_duty` = 10 mid-ramp → no accept, and the original ramp continues unchanged.
- **Kill mid-ramp:** at `duty_cur` = 2, raise `kill` → `pwm_out` = 0 next cycle, `duty_cur` = 0, `cmd_ready` = 0. Drop `kill` → IDLE, `cmd_ready` = 1.
- **Macro undefined:** accept 10 → `duty_cur` = 10 at the first `period_start`, then HOLD, and `pwm_out` is high 500 of every 1000 cycles.
